// File: rtl/alu_op_issuer.sv
// Command FIFO plus issue sequencer for a combinational alu: queues operand/opcode
// commands, drives them one at a time, and returns the registered result on a valid/ready channel.
module alu_op_issuer #(
    parameter int DATA_W     = 32,
    parameter int OP_W       = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_OP     = 7
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic [DATA_W-1:0]             cmd_a_i,
    input  logic [DATA_W-1:0]             cmd_b_i,
    input  logic [OP_W-1:0]               cmd_op_i,
    output logic [DATA_W-1:0]             alu_a_o,
    output logic [DATA_W-1:0]             alu_b_o,
    output logic [OP_W-1:0]               alu_op_o,
    input  logic [DATA_W-1:0]             alu_res_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [DATA_W-1:0]             rsp_data_o,
    output logic                          rsp_err_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   cmd_count_o
);
    // state | meaning
    // IDLE  | nothing in flight, waiting for a queued command
    // DRIVE | alu inputs driven, result settling this cycle
    // RESP  | result held on rsp_*, waiting for rsp_ready_i
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [OP_W-1:0]  MAX_OP_V = OP_W'(MAX_OP);

    logic [DATA_W-1:0] mem_a_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_a_d [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_b_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_b_d [FIFO_DEPTH];
    logic [OP_W-1:0]   mem_op_q [FIFO_DEPTH];
    logic [OP_W-1:0]   mem_op_d [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              push, pop, fifo_empty;

    // Ready depends only on registered occupancy, so a pop in the same cycle never frees a full FIFO.
    assign cmd_ready_o = (count_q != FULL_CNT);
    assign fifo_empty  = (count_q == '0);
    assign push        = cmd_valid_i && cmd_ready_o;

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        mem_a_d     = mem_a_q;
        mem_b_d     = mem_b_q;
        mem_op_d    = mem_op_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = (alu_op_q > MAX_OP_V);
                rsp_data_d  = rsp_err_d ? '0 : alu_res_i;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_DRIVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            alu_a_d  = mem_a_q[rd_ptr_q];
            alu_b_d  = mem_b_q[rd_ptr_q];
            alu_op_d = mem_op_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push) begin
            mem_a_d[wr_ptr_q]  = cmd_a_i;
            mem_b_d[wr_ptr_q]  = cmd_b_i;
            mem_op_d[wr_ptr_q] = cmd_op_i;
            wr_ptr_d           = wr_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_a_q[i]  <= '0;
                mem_b_q[i]  <= '0;
                mem_op_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            mem_a_q     <= mem_a_d;
            mem_b_q     <= mem_b_d;
            mem_op_q    <= mem_op_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_op_o    = alu_op_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = (state_q != ST_IDLE) || !fifo_empty;
    assign cmd_count_o = count_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench for alu_op_issuer: a reference alu on the issue port, a single-server queue
// model compared every cycle, plus directed literal checks and randomized traffic.
module tb_alu_op_issuer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_a, cmd_b;
    logic [4:0]  cmd_op;
    logic [31:0] alu_a, alu_b, alu_res;
    logic [4:0]  alu_op;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_data;
    logic [2:0]  cmd_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    alu_op_issuer dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_op_i(cmd_op),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_res_i(alu_res),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .busy_o(busy), .cmd_count_o(cmd_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] op);
        case (op)
            5'd0:    alu_fn = a + b;
            5'd1:    alu_fn = a - b;
            5'd2:    alu_fn = a << b[4:0];
            5'd3:    alu_fn = a >> b[4:0];
            5'd4:    alu_fn = a & b;
            5'd5:    alu_fn = a | b;
            5'd6:    alu_fn = a ^ b;
            5'd7:    alu_fn = {31'd0, a == b};
            default: alu_fn = 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb alu_res = alu_fn(alu_a, alu_b, alu_op);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of accepted-but-unanswered commands; the head is "in service" once issued,
    // and its response is visible from the edge after issue until the handshake.
    logic [31:0] q_a[$], q_b[$];
    logic [4:0]  q_op[$];
    int          issued = 0;
    int          age = 0;
    logic [31:0] last_a = '0, last_b = '0;
    logic [4:0]  last_op = '0;

    always @(posedge clk) begin
        int fifo_n;
        bit hs, acc;
        if (rst) begin
            q_a.delete(); q_b.delete(); q_op.delete();
            issued = 0; age = 0;
            last_a = '0; last_b = '0; last_op = '0;
        end else begin
            fifo_n = q_a.size() - issued;
            hs     = (issued == 1) && (age >= 1) && rsp_ready;
            acc    = cmd_valid && (fifo_n != DEPTH);
            if (hs) begin
                void'(q_a.pop_front()); void'(q_b.pop_front()); void'(q_op.pop_front());
                issued = 0;
            end
            if (issued == 0 && fifo_n > 0) begin
                issued = 1; age = 0;
                last_a = q_a[0]; last_b = q_b[0]; last_op = q_op[0];
            end else if (issued == 1) begin
                age = 1;
            end
            if (acc) begin
                q_a.push_back(cmd_a); q_b.push_back(cmd_b); q_op.push_back(cmd_op);
            end
        end
    end

    always @(posedge clk) begin
        bit ev;
        int ecount;
        #1;
        ev     = (issued == 1) && (age >= 1);
        ecount = q_a.size() - issued;
        check("m_rsp_valid", 32'(rsp_valid), 32'(ev));
        check("m_count", 32'(cmd_count), 32'(ecount));
        check("m_ready", 32'(cmd_ready), 32'(ecount != DEPTH));
        check("m_busy", 32'(busy), 32'(q_a.size() != 0));
        check("m_alu_a", alu_a, last_a);
        check("m_alu_b", alu_b, last_b);
        check("m_alu_op", 32'(alu_op), 32'(last_op));
        if (ev) begin
            check("m_rsp_err", 32'(rsp_err), 32'(q_op[0] > 5'd7));
            check("m_rsp_data", rsp_data, (q_op[0] > 5'd7) ? 32'd0 : alu_fn(q_a[0], q_b[0], q_op[0]));
        end
    end

    // All directed tasks start and end just after a falling edge.
    task automatic push_cmd(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        int n = 0;
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL push_timeout: cmd_ready_o stayed 0 for %0d cycles, expected 1", n);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [31:0] d, output logic e, output bit ok);
        int n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = rsp_valid;
        d  = rsp_data;
        e  = rsp_err;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: rsp_valid_o stayed 0 for %0d cycles, expected 1", n);
        end
    endtask

    task automatic do_one(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] op, input logic [31:0] ed, input logic ee);
        logic [31:0] d;
        logic e;
        bit ok;
        rsp_ready = 1'b1;
        push_cmd(a, b, op);
        wait_rsp(d, e, ok);
        if (ok) begin
            check({name, "_data"}, d, ed);
            check({name, "_err"}, 32'(e), 32'(ee));
        end
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic e;
        bit ok, seen;
        int prev;

        rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_count", 32'(cmd_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_data", rsp_data, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);

        // Latency: push at E0, pop at E1, response after E2.
        push_cmd(32'd5, 32'd3, 5'd0);
        check("lat_e0_valid", 32'(rsp_valid), 32'd0);
        check("lat_e0_count", 32'(cmd_count), 32'd1);
        @(negedge clk);
        check("lat_e1_valid", 32'(rsp_valid), 32'd0);
        check("lat_e1_alu_a", alu_a, 32'd5);
        check("lat_e1_alu_b", alu_b, 32'd3);
        @(negedge clk);
        check("lat_e2_valid", 32'(rsp_valid), 32'd1);
        check("lat_e2_data", rsp_data, 32'd8);
        check("lat_e2_err", 32'(rsp_err), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("lat_done_valid", 32'(rsp_valid), 32'd0);
        check("lat_done_busy", 32'(busy), 32'd0);

        do_one("sub", 32'd3, 32'd5, 5'd1, 32'hFFFF_FFFE, 1'b0);
        do_one("eql", 32'd7, 32'd7, 5'd7, 32'd1, 1'b0);
        do_one("sll", 32'h81, 32'd3, 5'd2, 32'h408, 1'b0);
        do_one("illegal", 32'd1, 32'd1, 5'd9, 32'd0, 1'b1);
        do_one("add11", 32'd1, 32'd1, 5'd0, 32'd2, 1'b0);

        // Backlog: one in flight plus a full FIFO, then a blocked extra command.
        for (int k = 0; k < 5; k++) push_cmd(32'(k), 32'd100, 5'd0);
        check("full_count", 32'(cmd_count), 32'd4);
        check("full_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b1; cmd_a = 32'd77; cmd_b = 32'd0; cmd_op = 5'd0;
        repeat (3) @(negedge clk);
        check("blocked_count", 32'(cmd_count), 32'd4);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_rsp(d, e, ok);
            if (ok) check("drain_data", d, 32'(k) + 32'd100);
            if (k > 0) check("drain_gap", 32'(cyc - prev), 32'd2);
            prev = cyc;
            @(negedge clk);
        end
        rsp_ready = 1'b0;

        // Reset while a response is pending and two commands are queued.
        for (int k = 0; k < 3; k++) push_cmd(32'd10 * 32'(k + 1), 32'd1, 5'd0);
        wait_rsp(d, e, ok);
        check("pre_rst_count", 32'(cmd_count), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_count", 32'(cmd_count), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        rsp_ready = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("no_stale_rsp", 32'(seen), 32'd0);
        rsp_ready = 1'b0;

        // Simultaneous push and pop at count 2.
        for (int k = 0; k < 3; k++) push_cmd(32'd40 + 32'(k), 32'd0, 5'd0);
        wait_rsp(d, e, ok);
        check("pp_first", d, 32'd40);
        check("pp_pre_count", 32'(cmd_count), 32'd2);
        cmd_valid = 1'b1; cmd_a = 32'd43; cmd_b = 32'd0; cmd_op = 5'd0;
        rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("pp_count", 32'(cmd_count), 32'd2);
        for (int k = 1; k < 4; k++) begin
            wait_rsp(d, e, ok);
            if (ok) check("pp_order", d, 32'd40 + 32'(k));
            @(negedge clk);
        end
        rsp_ready = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            cmd_valid = ($urandom_range(0, 99) < 60);
            cmd_a     = $urandom;
            cmd_b     = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
            cmd_op    = 5'($urandom_range(0, 10));
            rsp_ready = ($urandom_range(0, 99) < 50);
            rst       = ($urandom_range(0, 999) < 5);
            @(negedge clk);
        end
        cmd_valid = 1'b0; rst = 1'b0; rsp_ready = 1'b1;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
